// File: rtl/nic_packetizer_if.sv
// Request, payload and flit-channel bundle between a source and nic_packetizer.
// credit_in rides with the flit channel because it returns that channel's FIFO slots.
interface nic_packetizer_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        src_addr;
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_dst;
   logic [7:0]        req_len;
   logic              dat_valid;
   logic              dat_ready;
   logic [DATA_W-4:0] dat_in;
   logic              flit_valid;
   logic [DATA_W-1:0] flit_out;
   logic              credit_in;
   logic              busy;

   modport master (
      output src_addr, req_valid, req_dst, req_len,
      output dat_valid, dat_in, credit_in,
      input  req_ready, dat_ready, flit_valid, flit_out, busy
   );

   modport slave (
      input  src_addr, req_valid, req_dst, req_len,
      input  dat_valid, dat_in, credit_in,
      output req_ready, dat_ready, flit_valid, flit_out, busy
   );
endinterface

// File: rtl/nic_packetizer.sv
// nic_packetizer: request + payload stream -> HEADER/PAYLOAD/TAIL flits, credit flow control.
// Define SEQ_NUM_EN to stamp an 8-bit packet sequence number into header bits [23:16].
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module nic_packetizer #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CRD_W      = 3
) (
   input logic             clk,
   input logic             rst,
   nic_packetizer_if.slave bus
);
   localparam int BW = DATA_W - 3;
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FIFO_DEPTH);
   localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

   typedef enum logic [2:0] {
      IDLE, HEAD, BODY, TAIL, ZTAIL
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        dst_q, dst_d;
   logic [3:0]        src_q, src_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        rem_q, rem_d;
   logic [CRD_W-1:0]  credits_q, credits_d;
   logic              flit_valid_q, flit_valid_d;
   logic [DATA_W-1:0] flit_out_q, flit_out_d;
   logic [7:0]        seq_num;
   logic [BW-1:0]     hdr_body;
   logic              has_crd;
   logic              emit;

   assign has_crd        = (credits_q != '0);
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.flit_valid = flit_valid_q;
   assign bus.flit_out   = flit_out_q;

   always_comb begin
      hdr_body        = '0;
      hdr_body[3:0]   = dst_q;
      hdr_body[7:4]   = src_q;
      hdr_body[15:8]  = len_q;
      hdr_body[23:16] = seq_num;
   end

   always_comb begin
      state_d       = state_q;
      dst_d         = dst_q;
      src_d         = src_q;
      len_d         = len_q;
      rem_d         = rem_q;
      flit_out_d    = flit_out_q;
      emit          = 1'b0;
      bus.dat_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               dst_d   = bus.req_dst;
               src_d   = bus.src_addr;
               len_d   = bus.req_len;
               rem_d   = bus.req_len;
               state_d = HEAD;
            end
         end
         HEAD: begin
            if (has_crd) begin
               emit       = 1'b1;
               flit_out_d = {`HEADER, hdr_body};
               if (len_q >= 8'd2)      state_d = BODY;
               else if (len_q == 8'd1) state_d = TAIL;
               else                    state_d = ZTAIL;
            end
         end
         BODY: begin
            if (has_crd && bus.dat_valid) begin
               bus.dat_ready = 1'b1;
               emit          = 1'b1;
               flit_out_d    = {`PAYLOAD, bus.dat_in};
               rem_d         = rem_q - 8'd1;
               if (rem_q == 8'd2) state_d = TAIL;
            end
         end
         TAIL: begin
            if (has_crd && bus.dat_valid) begin
               bus.dat_ready = 1'b1;
               emit          = 1'b1;
               flit_out_d    = {`TAIL, bus.dat_in};
               rem_d         = rem_q - 8'd1;
               state_d       = IDLE;
            end
         end
         ZTAIL: begin
            if (has_crd) begin
               emit       = 1'b1;
               flit_out_d = {`TAIL, {BW{1'b0}}};
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      flit_valid_d = emit;
   end

   // A returned credit cancels an emit in the same cycle; overflow saturates.
   always_comb begin
      credits_d = credits_q;
      if (emit && !bus.credit_in)
         credits_d = credits_q - CRD_ONE;
      else if (!emit && bus.credit_in && credits_q != CRD_MAX)
         credits_d = credits_q + CRD_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dst_q        <= '0;
         src_q        <= '0;
         len_q        <= '0;
         rem_q        <= '0;
         credits_q    <= CRD_MAX;
         flit_valid_q <= 1'b0;
         flit_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         dst_q        <= dst_d;
         src_q        <= src_d;
         len_q        <= len_d;
         rem_q        <= rem_d;
         credits_q    <= credits_d;
         flit_valid_q <= flit_valid_d;
         flit_out_q   <= flit_out_d;
      end
   end

`ifdef SEQ_NUM_EN
   logic [7:0] seq_q, seq_d;

   always_comb begin
      seq_d = seq_q;
      if (emit && flit_out_d[DATA_W-1 -: 3] == `TAIL)
         seq_d = seq_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) seq_q <= '0;
      else     seq_q <= seq_d;
   end

   assign seq_num = seq_q;
`else
   assign seq_num = 8'd0;
`endif

   a_credit_overflow: assert property (
      @(posedge clk) disable iff (rst)
      !(bus.credit_in && credits_q == CRD_MAX)
   );

endmodule
